clock_phase_gen: RTL
====================

CLOCK_PHASE_GEN -- requirements
Module: clock_phase_gen

Interface
REQ-001 Parameter HALF_PERIOD, default 400, CLOCK_50 cycles per cpu_phi half-period; SHALL be >= 2.
REQ-002 Parameter MEM_RATIO, default 4, mem_phi toggles per cpu_phi half-period; SHALL divide HALF_PERIOD exactly; elaboration SHALL fail otherwise.
REQ-003 Parameter VID_RATIO, default 1, cpu_phi half-periods per vid_phi toggle; SHALL be >= 1.
REQ-004 CLOCK_50  in  1  sole clock; all logic on posedge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 run  in  1  level; 1 = free-running clocks, 0 = halt at next cpu cycle boundary.
REQ-007 step  in  1  one-cycle pulse; requests exactly one full cpu cycle while halted.
REQ-008 cpu_phi  out  1  CPU phase clock.
REQ-009 mem_phi  out  1  memory phase clock, MEM_RATIO toggles per cpu half-period.
REQ-010 vid_phi  out  1  video phase clock.
REQ-011 cpu_rise  out  1  one-cycle strobe, high in the cycle cpu_phi first reads 1.
REQ-012 cpu_fall  out  1  one-cycle strobe, high in the cycle cpu_phi first reads 0.
REQ-013 halted  out  1  1 while in HALT state.

Function
REQ-014 Internal counter cnt, width clog2(HALF_PERIOD), range 0..HALF_PERIOD-1; advances by 1 per cycle only in RUN, DRAIN, STEP.
REQ-015 Advancing with cnt == HALF_PERIOD-1: cnt -> 0, cpu_phi toggles, same edge.
REQ-016 Advancing with (cnt+1) mod (HALF_PERIOD/MEM_RATIO) == 0: mem_phi toggles, same edge; coincides with every cpu_phi toggle.
REQ-017 Internal vid counter 0..VID_RATIO-1 increments on each cpu_phi toggle; on wrap to 0, vid_phi toggles on the same edge as cpu_phi.
REQ-018 cpu_rise/cpu_fall registered: asserted exactly one cycle, the cycle after the edge on which cpu_phi toggled to 1/0; never both high.
REQ-019 In HALT, cnt, vid counter, cpu_phi, mem_phi, vid_phi all hold; strobes low.
REQ-020 States RUN, DRAIN, HALT, STEP, 2-bit encoding.
REQ-021 RUN: run == 0 -> DRAIN; else stay.
REQ-022 DRAIN: counting continues; on the edge cpu_phi toggles 1 -> 0 -> HALT; run reasserted before that edge -> RUN, no halt.
REQ-023 DRAIN entered with cpu_phi == 0 first completes the high half, then halts at the following falling toggle (halt only at cpu_phi 1 -> 0 boundary).
REQ-024 HALT: run == 1 -> RUN (run wins over simultaneous step); else step == 1 -> STEP; else stay.
REQ-025 STEP: counts exactly 2*HALF_PERIOD cycles (one high, one low cpu half) then -> HALT on the 1 -> 0 toggle; step and run ignored inside STEP.
REQ-026 step ignored in RUN and DRAIN; no step queued.
REQ-027 Halting leaves cpu_phi = 0, cnt = 0, mem_phi at its value after the boundary toggle; resumption is phase-continuous from there.

Reset
REQ-028 reset_n == 0 sampled at posedge: cpu_phi = 0, mem_phi = 1, vid_phi = 1, cnt = 0, vid counter = 0, cpu_rise = cpu_fall = 0.
REQ-029 Reset state: RUN if run == 1 at the releasing edge's next cycle, i.e. state resets to RUN, halted = 0; with run == 0 it follows REQ-021 to DRAIN.
REQ-030 Reset mid-DRAIN or mid-STEP SHALL abort the cycle immediately; no partial-cycle resumption.

Verification (HALF_PERIOD = 4, MEM_RATIO = 2, VID_RATIO = 2)
REQ-031 Reset, run = 1, 24 cycles -> cpu_phi period 8, mem_phi period 4 toggling with every cpu_phi toggle, vid_phi period 16; first cpu_phi rise 4 cycles after reset release.
REQ-032 run = 1, drop run while cpu_phi = 1 and cnt = 1 -> counting continues 3 cycles, cpu_phi falls, halted = 1 next cycle, cpu_fall pulses once, outputs frozen 20 cycles.
REQ-033 Halted, step pulse -> exactly 8 counted cycles, one cpu_rise and one cpu_fall, mem_phi 4 toggles, then halted = 1; second step pulse during STEP ignored.
REQ-034 Halted, run and step both 1 same cycle -> RUN, free-running, no return to HALT.
REQ-035 Drop run then reassert before the falling boundary -> halted never asserts, cpu_phi period unchanged at 8.
REQ-036 reset_n low 1 cycle mid-STEP -> next cycle cpu_phi = 0, mem_phi = 1, vid_phi = 1, strobes 0, counting restarts from cnt = 0.

Source files
------------

// File: rtl/clock_phase_gen_if.sv
// Run/step control and phase-clock outputs of clock_phase_gen.
// The controller side uses master and clock_phase_gen uses slave.
interface clock_phase_gen_if;
    logic run;
    logic step;
    logic cpu_phi;
    logic mem_phi;
    logic vid_phi;
    logic cpu_rise;
    logic cpu_fall;
    logic halted;

    modport master (
        output run,
        output step,
        input  cpu_phi,
        input  mem_phi,
        input  vid_phi,
        input  cpu_rise,
        input  cpu_fall,
        input  halted
    );

    modport slave (
        input  run,
        input  step,
        output cpu_phi,
        output mem_phi,
        output vid_phi,
        output cpu_rise,
        output cpu_fall,
        output halted
    );
endinterface

// File: rtl/clock_phase_gen.sv
// Generates CPU, memory and video phase clocks from CLOCK_50. It supports
// free-running, halt at a cpu_phi falling boundary, and single-cycle stepping.
module clock_phase_gen #(
    parameter int unsigned HALF_PERIOD = 400,
    parameter int unsigned MEM_RATIO   = 4,
    parameter int unsigned VID_RATIO   = 1
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    clock_phase_gen_if.slave   bus
);

    localparam int unsigned MEM_DIV = HALF_PERIOD / MEM_RATIO;
    localparam int unsigned CNT_W   = $clog2(HALF_PERIOD);
    localparam int unsigned MCNT_W  = (MEM_DIV > 1) ? $clog2(MEM_DIV) : 1;
    localparam int unsigned VCNT_W  = (VID_RATIO > 1) ? $clog2(VID_RATIO) : 1;

    // Reject parameter sets that cannot produce aligned phase clocks.
    if (HALF_PERIOD < 2 || MEM_RATIO == 0 || (HALF_PERIOD % MEM_RATIO) != 0
        || VID_RATIO < 1) begin : g_bad_params
        $error("clock_phase_gen: illegal HALF_PERIOD/MEM_RATIO/VID_RATIO");
    end

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2,
        S_STEP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_halted;

    logic [CNT_W-1:0]    r_cnt;
    logic [MCNT_W-1:0]   r_mcnt;
    logic [VCNT_W-1:0]   r_vcnt;
    logic                r_cpu_phi;
    logic                r_mem_phi;
    logic                r_vid_phi;
    logic                r_cpu_rise;
    logic                r_cpu_fall;

    logic                w_adv;
    logic                w_cnt_wrap;
    logic                w_cpu_tog;
    logic                w_mem_tog;
    logic                w_vid_wrap;
    logic                w_fall_edge;

    // The memory sub-counter divides HALF_PERIOD exactly, so it stays
    // aligned with cnt and wraps on every cpu_phi toggle.
    assign w_adv       = (r_state != S_HALT);
    assign w_cnt_wrap  = (r_cnt == CNT_W'(HALF_PERIOD - 1));
    assign w_cpu_tog   = w_adv & w_cnt_wrap;
    assign w_mem_tog   = w_adv & (r_mcnt == MCNT_W'(MEM_DIV - 1));
    assign w_vid_wrap  = (r_vcnt == VCNT_W'(VID_RATIO - 1));
    assign w_fall_edge = w_cpu_tog & r_cpu_phi;

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= (w_state_nxt == S_HALT);
        end
    end

    // Next-state logic. A halt is allowed only on a cpu_phi 1 -> 0 boundary.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (!bus.run) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.run)          w_state_nxt = S_RUN;
                else if (w_fall_edge) w_state_nxt = S_HALT;
            end
            S_HALT: begin
                if (bus.run)       w_state_nxt = S_RUN;
                else if (bus.step) w_state_nxt = S_STEP;
            end
            S_STEP: begin
                if (w_fall_edge) w_state_nxt = S_HALT;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Phase counters and clocks. Every value holds while the state is HALT.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_mcnt     <= '0;
            r_vcnt     <= '0;
            r_cpu_phi  <= 1'b0;
            r_mem_phi  <= 1'b1;
            r_vid_phi  <= 1'b1;
            r_cpu_rise <= 1'b0;
            r_cpu_fall <= 1'b0;
        end else begin
            r_cpu_rise <= w_cpu_tog & ~r_cpu_phi;
            r_cpu_fall <= w_fall_edge;
            if (w_adv) begin
                r_cnt  <= w_cnt_wrap ? '0 : r_cnt + CNT_W'(1);
                r_mcnt <= (w_mem_tog || w_cnt_wrap) ? '0 : r_mcnt + MCNT_W'(1);
            end
            if (w_mem_tog) begin
                r_mem_phi <= ~r_mem_phi;
            end
            if (w_cpu_tog) begin
                r_cpu_phi <= ~r_cpu_phi;
                r_vcnt    <= w_vid_wrap ? '0 : r_vcnt + VCNT_W'(1);
                if (w_vid_wrap) begin
                    r_vid_phi <= ~r_vid_phi;
                end
            end
        end
    end

    assign bus.cpu_phi  = r_cpu_phi;
    assign bus.mem_phi  = r_mem_phi;
    assign bus.vid_phi  = r_vid_phi;
    assign bus.cpu_rise = r_cpu_rise;
    assign bus.cpu_fall = r_cpu_fall;
    assign bus.halted   = r_halted;

endmodule
